// File: rtl/sort_frame_ctrl.sv
// Frame sequencer for the paixu sort/max pipeline: clears the core, gates
// exactly frame_len samples into it, waits out the core latency and
// captures the core's running maximum as the frame result.
module sort_frame_ctrl #(
  parameter int DW       = 8,
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [DW-1:0]    s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             core_clr,
  output logic             core_en,
  output logic [DW-1:0]    core_data,
  input  logic [DW-1:0]    core_max,
  output logic [DW-1:0]    res_data,
  output logic             res_valid,
  output logic             done,
  output logic             err,
  output logic             busy
);

  localparam int DRN_W = $clog2(PIPE_LAT + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_DRAIN,
    S_REPORT
  } state_t;

  state_t             state;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [LEN_W-1:0]   cnt_nxt;
  logic [DRN_W-1:0]   drn_q;
  logic               abort_q;

  // Moore decodes of the current state
  always_comb begin
    s_ready  = (state == S_LOAD);
    core_clr = (state == S_CLEAR);
    busy     = (state != S_IDLE);
    cnt_nxt  = cnt_q + LEN_W'(1);
  end

  // Frame sequencing FSM with registered core/result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      drn_q     <= '0;
      abort_q   <= 1'b0;
      core_en   <= 1'b0;
      core_data <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      core_en   <= 1'b0;
      res_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      // Abort reuses CLEAR for its clearing cycle; abort_q sends CLEAR to IDLE
      if (abort && state != S_IDLE) begin
        state   <= S_CLEAR;
        abort_q <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (frame_len != '0) begin
                len_q   <= frame_len;
                cnt_q   <= '0;
                abort_q <= 1'b0;
                state   <= S_CLEAR;
              end else begin
                err <= 1'b1;
              end
            end
          end
          S_CLEAR: begin
            abort_q <= 1'b0;
            state   <= abort_q ? S_IDLE : S_LOAD;
          end
          S_LOAD: begin
            if (s_valid) begin
              core_en   <= 1'b1;
              core_data <= s_data;
              cnt_q     <= cnt_nxt;
              if (cnt_nxt == len_q) begin
                drn_q <= DRN_W'(PIPE_LAT + 1);
                state <= S_DRAIN;
              end
            end
          end
          S_DRAIN: begin
            drn_q <= drn_q - DRN_W'(1);
            if (drn_q == DRN_W'(1)) state <= S_REPORT;
          end
          S_REPORT: begin
            res_data  <= core_max;
            res_valid <= 1'b1;
            done      <= 1'b1;
            state     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sort_frame_ctrl.sv
// Self-checking bench for sort_frame_ctrl with a running-max core model.
module tb_sort_frame_ctrl;

  localparam int DW       = 8;
  localparam int LEN_W    = 8;
  localparam int PIPE_LAT = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [LEN_W-1:0] frame_len = '0;
  logic [DW-1:0]    s_data = '0;
  logic             s_valid = 1'b0;
  logic             s_ready, core_clr, core_en, res_valid, done, err, busy;
  logic [DW-1:0]    core_data, res_data, core_max;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0, clr_cnt = 0, done_cnt = 0, err_cnt = 0;

  logic [DW-1:0] smp[$];

  always #5 clk = ~clk;

  sort_frame_ctrl #(.DW(DW), .LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .frame_len(frame_len), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .core_clr(core_clr), .core_en(core_en),
    .core_data(core_data), .core_max(core_max), .res_data(res_data),
    .res_valid(res_valid), .done(done), .err(err), .busy(busy)
  );

  // Core model: running max, PIPE_LAT cycles from core_en to core_max update
  logic [DW-1:0] pd[PIPE_LAT];
  logic          pv[PIPE_LAT];
  logic [DW-1:0] cmax;
  assign core_max = cmax;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmax <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin pv[i] <= 1'b0; pd[i] <= '0; end
    end else if (core_clr) begin
      cmax <= '0;
      for (int i = 0; i < PIPE_LAT; i++) pv[i] <= 1'b0;
    end else begin
      if (pv[PIPE_LAT-1] && pd[PIPE_LAT-1] > cmax) cmax <= pd[PIPE_LAT-1];
      pv[0] <= core_en;
      pd[0] <= core_data;
      for (int i = 1; i < PIPE_LAT; i++) begin pv[i] <= pv[i-1]; pd[i] <= pd[i-1]; end
    end
  end

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (core_en)  en_cnt++;
    if (core_clr) clr_cnt++;
    if (done)     done_cnt++;
    if (err)      err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame from the samples in smp; mode 0 = continuous valid,
  // 1 = valid every other cycle, 2 = random gaps. start_at >= 0 pulses a
  // stray start while LOAD is presenting sample start_at.
  task automatic run_frame(input int L, input int mode, input int start_at,
                           output logic [DW-1:0] got, output int lat);
    int k, idx, stalls, en0, clr0, err0;
    bit alt, stray_done, v;
    logic [DW-1:0] exp_max;
    exp_max = '0;
    foreach (smp[i]) if (smp[i] > exp_max) exp_max = smp[i];
    en0 = en_cnt; clr0 = clr_cnt; err0 = err_cnt;
    start = 1'b1; frame_len = L[LEN_W-1:0];
    step();
    start = 1'b0;
    k = 0; idx = 0; stalls = 0; alt = 1'b1; stray_done = 1'b0;
    chk("clr_cycle1", core_clr, 1);
    chk("busy_cycle1", busy, 1);
    while (!res_valid && k < 600) begin
      start = 1'b0;
      frame_len = L[LEN_W-1:0];
      if (start_at >= 0 && idx == start_at && s_ready && !stray_done) begin
        start = 1'b1; frame_len = LEN_W'(L + 2); stray_done = 1'b1;
      end
      if (s_ready && idx < L) begin
        case (mode)
          0:       v = 1'b1;
          1:       begin v = alt; alt = !alt; end
          default: v = 1'($urandom_range(0, 1));
        endcase
        if (v) begin s_valid = 1'b1; s_data = smp[idx]; idx++; end
        else begin s_valid = 1'b0; s_data = DW'($urandom); stalls++; end
      end else begin
        s_valid = 1'b0;
      end
      step();
      k++;
    end
    s_valid = 1'b0; start = 1'b0;
    lat = k + 1;
    chk("res_valid_seen", res_valid, 1);
    chk("done_with_res", done, 1);
    chk("latency", lat, 1 + L + (PIPE_LAT + 1) + 1 + 1 + stalls);
    chk("res_data", res_data, exp_max);
    chk("en_pulses", en_cnt - en0, L);
    chk("clr_cycles", clr_cnt - clr0, 1);
    chk("no_err", err_cnt - err0, 0);
    chk("idle_at_done", busy, 0);
    got = res_data;
  endtask

  initial begin
    logic [DW-1:0] got, prev;
    int lat, idx, en0, clr0, done0, L;

    // Reset state
    step(); step();
    chk("rst_outputs", {s_ready, core_clr, core_en, core_data, res_data,
                        res_valid, done, err, busy}, 0);
    rst_n = 1'b1;
    step();

    // Directed frame: len 4, samples 12,200,7,99
    smp = '{8'd12, 8'd200, 8'd7, 8'd99};
    run_frame(4, 0, -1, got, lat);
    chk("f1_lat", lat, 11);
    chk("f1_max", got, 200);
    step();
    chk("res_valid_pulse", res_valid, 0);
    chk("res_data_hold", res_data, 200);

    // Same frame with valid every other cycle
    run_frame(4, 1, -1, got, lat);
    chk("gap_lat", lat, 14);
    chk("gap_max", got, 200);

    // Zero-length start
    clr0 = clr_cnt;
    start = 1'b1; frame_len = '0;
    step();
    start = 1'b0;
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    chk("err_no_clr", core_clr, 0);
    step();
    chk("err_one_cycle", err, 0);
    chk("err_clr_count", clr_cnt - clr0, 0);

    // Abort after 2 of 5 samples
    prev = res_data;
    smp = '{8'd3, 8'd250, 8'd4, 8'd5, 8'd6};
    en0 = en_cnt; clr0 = clr_cnt; done0 = done_cnt;
    start = 1'b1; frame_len = 8'd5;
    step();
    start = 1'b0;
    idx = 0;
    for (int t = 0; t < 20 && idx < 2; t++) begin
      if (s_ready) begin s_valid = 1'b1; s_data = smp[idx]; idx++; end
      else s_valid = 1'b0;
      step();
    end
    abort = 1'b1; s_valid = 1'b1; s_data = smp[2];
    step();
    abort = 1'b0; s_valid = 1'b0;
    chk("abort_clr", core_clr, 1);
    chk("abort_busy", busy, 1);
    chk("abort_no_res", res_valid, 0);
    step();
    chk("abort_idle", busy, 0);
    chk("abort_clr_off", core_clr, 0);
    step(); step();
    chk("abort_en_pulses", en_cnt - en0, 2);
    chk("abort_clr_cycles", clr_cnt - clr0, 2);
    chk("abort_no_done", done_cnt - done0, 0);
    chk("abort_res_hold", res_data, prev);

    smp = '{8'h55};
    run_frame(1, 0, -1, got, lat);
    chk("post_abort_res", got, 8'h55);

    // Back-to-back frames, start in the done cycle
    smp = '{8'd1, 8'd2, 8'd3};
    run_frame(3, 0, -1, got, lat);
    chk("b2b_first", got, 3);
    smp = '{8'd9, 8'd4};
    run_frame(2, 0, -1, got, lat);
    chk("b2b_second", got, 9);
    smp = '{8'd5, 8'd2};
    run_frame(2, 0, -1, got, lat);
    chk("b2b_cleared", got, 5);

    // Stray start during LOAD is ignored
    smp = '{8'd40, 8'd80, 8'd20};
    run_frame(3, 0, 1, got, lat);
    chk("stray_start_res", got, 80);

    // Random frames with random upstream gaps
    for (int f = 0; f < 8; f++) begin
      L = int'($urandom_range(1, 24));
      smp = {};
      for (int i = 0; i < L; i++) smp.push_back(DW'($urandom));
      run_frame(L, 2, -1, got, lat);
    end

    // Asynchronous reset during DRAIN
    smp = '{8'd7, 8'd8, 8'd9};
    start = 1'b1; frame_len = 8'd3;
    step();
    start = 1'b0;
    idx = 0;
    for (int t = 0; t < 20 && idx < 3; t++) begin
      if (s_ready) begin s_valid = 1'b1; s_data = smp[idx]; idx++; end
      else s_valid = 1'b0;
      step();
    end
    s_valid = 1'b0;
    step();
    chk("drain_busy", busy, 1);
    chk("drain_not_ready", s_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {s_ready, core_clr, core_en, core_data, res_data,
                            res_valid, done, err, busy}, 0);
    step();
    chk("rst_hold_idle", busy, 0);
    rst_n = 1'b1;
    step();
    chk("rst_release_idle", {busy, res_valid, done}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sort_frame_ctrl.md
# sort_frame_ctrl

Frame sequencer for the paixu streaming sort/max pipeline. Accepts a start command and frame length, clears the sorting core, then gates exactly `frame_len` samples from an upstream valid/ready stream into it. It waits out the core's pipeline latency, then captures the core's running maximum as the frame result. It sits between the sample source and the sorting core and owns all core sequencing.

## Interface

- `DW`, 8: sample and result width.
- `LEN_W`, 8: frame-length width; maximum frame is 2^LEN_W−1 samples.
- `PIPE_LAT`, 3: core latency in cycles from `core_en` sample to `core_max` update.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset. Asynchronous, active-low. This is the block's only reset.
- `start`  in  1  frame request; sampled only in IDLE.
- `abort`  in  1  synchronous abort; effective in any non-IDLE state.
- `frame_len`  in  LEN_W  samples in the frame; latched when `start` is accepted.
- `s_data`  in  DW  upstream sample.
- `s_valid`  in  1  upstream sample valid.
- `s_ready`  out  1  block accepts a sample; Moore decode, high only in LOAD.
- `core_clr`  out  1  core clear; Moore decode, high only in CLEAR.
- `core_en`  out  1  registered; high one cycle per accepted sample.
- `core_data`  out  DW  registered sample to core; holds its last value when `core_en` is 0.
- `core_max`  in  DW  core running-maximum output.
- `res_data`  out  DW  registered frame result; holds until the next result.
- `res_valid`  out  1  one-cycle pulse with a new `res_data`.
- `done`  out  1  one-cycle pulse, coincident with `res_valid`.
- `err`  out  1  one-cycle pulse when `start` is rejected because `frame_len`==0.
- `busy`  out  1  high in every state except IDLE.

## Operation

- States: IDLE, CLEAR, LOAD, DRAIN, REPORT. Reset enters IDLE.
- Reset values: all outputs 0; internal counters 0.
- **IDLE**
  - `start`=1 and `frame_len`≠0: latch the length, clear the sample count, go to CLEAR.
  - `start`=1 and `frame_len`==0: pulse `err`, stay in IDLE.
- **CLEAR**: lasts exactly one cycle with `core_clr`=1, then goes to LOAD.
- **LOAD**
  - On each edge with `s_valid`&`s_ready`: `core_en`<=1, `core_data`<=`s_data`, and the count increments. On other edges `core_en`<=0.
  - The edge that accepts sample number `len` goes to DRAIN and loads the drain counter with `PIPE_LAT`+1.
  - `s_valid` gaps are allowed and only stretch LOAD.
- **DRAIN**
  - `s_ready`=0.
  - The drain counter decrements each cycle. On the edge where it reaches 0, go to REPORT. DRAIN therefore lasts exactly `PIPE_LAT`+1 cycles.
- **REPORT**: lasts one cycle. On the exit edge: `res_data`<=`core_max`, `res_valid`<=1, `done`<=1, go to IDLE.
- **abort** in CLEAR, LOAD, DRAIN or REPORT:
  - Go to CLEAR-then-IDLE: one cycle with `core_clr`=1, then IDLE.
  - No `res_valid` and no `done`.
  - `res_data` is unchanged.
  - `core_en`<=0 on the abort edge; the sample offered on that edge is not accepted.
- `abort` takes priority over every other transition. `start` is ignored while `busy`=1.
- Counters are LEN_W wide and are compared for equality with the latched length. They never wrap within a frame.
- Asynchronous reset mid-frame returns immediately to IDLE with all outputs 0. The core is expected to share `rst_n`.

## Timing

- Example with L=4, `PIPE_LAT`=3, `start` sampled at edge 0, `s_valid` held high:
  - CLEAR: cycle 1.
  - LOAD: cycles 2–5, with `core_en` high in cycles 3–6.
  - DRAIN: cycles 6–9.
  - REPORT: cycle 10.
  - `res_valid`/`done`: cycle 11.
- General latency from the `start` edge to `res_valid` is 1 + L + (`PIPE_LAT`+1) + 1 + 1 cycles, plus any upstream stall cycles.
- Back-to-back frames: `start` may be asserted in the cycle that `done` is high. The next CLEAR begins in the following cycle.
- `s_ready` has no combinational path from `s_valid`.

## Test plan

- Reset release, then a frame with len=4 and samples 12, 200, 7, 99, using a bench core model (running max, latency 3) -> `res_data`=200, `res_valid` and `done` in cycle 11, `core_clr` exactly in cycle 1, exactly 4 `core_en` pulses.
- Same frame with `s_valid` low every other cycle -> same result, LOAD extended by 3 cycles, no duplicated or dropped `core_en`.
- `start` with `frame_len`=0 -> `err` pulses for one cycle, `busy` stays 0, no `core_clr`.
- `abort` after 2 of 5 samples -> one `core_clr` cycle, then IDLE, no `done`, `res_data` keeps its previous value. A following len=1 frame with sample 0x55 -> `res_data`=0x55.
- Back-to-back frames (len=3: 1, 2, 3, then len=2: 9, 4) with `start` asserted in the `done` cycle -> results 3, then 9. The core is cleared between frames, so the second result is not max(3, 9) carried over from frame 1.
- `start` pulsed during LOAD, and `rst_n` asserted during DRAIN -> the `start` is ignored; on reset all outputs read 0 immediately and the FSM is in IDLE.
